// File: rtl/ureg_pkg.sv
// Shared definitions for the universal register: operation encoding and widths.
package ureg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] HOLD = 3'd0;
  localparam logic [MODE_W-1:0] LOAD = 3'd1;
  localparam logic [MODE_W-1:0] SHL  = 3'd2;
  localparam logic [MODE_W-1:0] SHR  = 3'd3;
  localparam logic [MODE_W-1:0] INC  = 3'd4;
  localparam logic [MODE_W-1:0] DEC  = 3'd5;
  localparam logic [MODE_W-1:0] ROL  = 3'd6;
  localparam logic [MODE_W-1:0] ROR  = 3'd7;

endpackage

// File: rtl/ureg_bit.sv
// One bit of the universal register: next-state select plus flop.
// Neighbour and arithmetic sources are prepared by the parent.
module ureg_bit
  import ureg_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              clrbar,
  input  logic              sclr,
  input  logic              ce,
  input  logic [MODE_W-1:0] mode,
  input  logic              d,
  input  logic              shl_src,
  input  logic              shr_src,
  input  logic              rol_src,
  input  logic              ror_src,
  input  logic              inc_src,
  input  logic              dec_src,
  output logic              q
);

  always_ff @(posedge clk or negedge clrbar) begin
    if (!clrbar) begin
      q <= RST_BIT;
    end else if (sclr) begin
      q <= RST_BIT;
    end else if (ce) begin
      case (mode)
        HOLD:    q <= q;
        LOAD:    q <= d;
        SHL:     q <= shl_src;
        SHR:     q <= shr_src;
        INC:     q <= inc_src;
        DEC:     q <= dec_src;
        ROL:     q <= rol_src;
        ROR:     q <= ror_src;
        // An unknown mode must poison the bit rather than silently hold.
        default: q <= 1'bx;
      endcase
    end
  end

endmodule

// File: rtl/ureg_ce.sv
// Universal register with clock enable, sync/async clear, shift/rotate,
// increment/decrement and a registered carry/borrow pulse.
module ureg_ce
  import ureg_pkg::*;
#(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic              clk,
  input  logic              clrbar,
  input  logic              ce,
  input  logic              sclr,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qbar,
  output logic              co,
  output logic              sout
);

  logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v, inc_v, dec_v;

  assign shl_v = {q[WIDTH-2:0], sin};
  assign shr_v = {sin, q[WIDTH-1:1]};
  assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};
  assign ror_v = {q[0], q[WIDTH-1:1]};
  assign inc_v = q + {{(WIDTH-1){1'b0}}, 1'b1};
  assign dec_v = q - {{(WIDTH-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ureg_bit #(
      .RST_BIT (RST_VAL[i])
    ) u_bit (
      .clk     (clk),
      .clrbar  (clrbar),
      .sclr    (sclr),
      .ce      (ce),
      .mode    (mode),
      .d       (d[i]),
      .shl_src (shl_v[i]),
      .shr_src (shr_v[i]),
      .rol_src (rol_v[i]),
      .ror_src (ror_v[i]),
      .inc_src (inc_v[i]),
      .dec_src (dec_v[i]),
      .q       (q[i])
    );
  end

  // co marks the wrap of the edge just taken, so it is cleared by anything
  // that is not an actual INC/DEC wrap.
  always_ff @(posedge clk or negedge clrbar) begin
    if (!clrbar) begin
      co <= 1'b0;
    end else if (sclr || !ce) begin
      co <= 1'b0;
    end else begin
      co <= ((mode == INC) && (&q)) || ((mode == DEC) && (q == '0));
    end
  end

  assign qbar = ~q;

  always_comb begin
    sout = 1'b0;
    case (mode)
      SHL, ROL: sout = q[WIDTH-1];
      SHR, ROR: sout = q[0];
      default:  sout = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ureg_ce.sv
// Directed bench for ureg_ce: one instance with RST_VAL=0 checked through an
// expected-value scoreboard, one with RST_VAL=8'h5A checked directly.
module tb_ureg_ce;
  import ureg_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clrbar, ce, sclr, sin;
  logic [2:0] mode;
  logic [7:0] d, q, qbar;
  logic       co, sout;

  logic       clrbar2, ce2, sclr2, sin2;
  logic [2:0] mode2;
  logic [7:0] d2, q2, qbar2;
  logic       co2, sout2;

  ureg_ce #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk(clk), .clrbar(clrbar), .ce(ce), .sclr(sclr), .mode(mode),
    .d(d), .sin(sin), .q(q), .qbar(qbar), .co(co), .sout(sout)
  );

  ureg_ce #(.WIDTH(8), .RST_VAL(8'h5A)) dut2 (
    .clk(clk), .clrbar(clrbar2), .ce(ce2), .sclr(sclr2), .mode(mode2),
    .d(d2), .sin(sin2), .q(q2), .qbar(qbar2), .co(co2), .sout(sout2)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  logic       exp_co[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every edge with a pending expectation is checked just after it
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cmp("q", {56'd0, q}, {56'd0, exp_q.pop_front()});
      cmp("co", {63'd0, co}, {63'd0, exp_co.pop_front()});
      cmp("qbar", {56'd0, qbar}, {56'd0, ~q});
    end
  end

  // driver: apply one cycle of inputs, check pre-edge sout, queue the result
  task automatic step(input logic [2:0] m, input logic [7:0] dv, input logic s,
                      input logic c, input logic sc, input logic [7:0] eq,
                      input logic eco, input logic esout);
    @(negedge clk);
    mode = m; d = dv; sin = s; ce = c; sclr = sc;
    exp_q.push_back(eq);
    exp_co.push_back(eco);
    #1;
    cmp("sout", {63'd0, sout}, {63'd0, esout});
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    cmp("drain", {32'd0, 32'(exp_q.size())}, 64'd0);
  endtask

  logic [7:0] rol_q[8]  = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
  logic       rol_so[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    clrbar = 1'b0; ce = 1'b0; sclr = 1'b0; mode = HOLD; d = 8'h00; sin = 1'b0;
    clrbar2 = 1'b0; ce2 = 1'b0; sclr2 = 1'b0; mode2 = HOLD; d2 = 8'h00; sin2 = 1'b0;
    #12;
    cmp("rst_q", {56'd0, q}, 64'h00);
    cmp("rst_qbar", {56'd0, qbar}, 64'hFF);
    cmp("rst_co", {63'd0, co}, 64'd0);
    cmp("rst2_q", {56'd0, q2}, 64'h5A);
    cmp("rst2_qbar", {56'd0, qbar2}, 64'hA5);
    cmp("rst2_co", {63'd0, co2}, 64'd0);

    // RST_VAL instance: sclr beats LOAD, then LOAD proves the path works
    @(negedge clk);
    clrbar2 = 1'b1; sclr2 = 1'b1; ce2 = 1'b1; mode2 = LOAD; d2 = 8'hFF;
    @(posedge clk); #1;
    cmp("sclr2_q", {56'd0, q2}, 64'h5A);
    @(negedge clk);
    sclr2 = 1'b0;
    @(posedge clk); #1;
    cmp("load2_q", {56'd0, q2}, 64'hFF);

    @(negedge clk);
    clrbar = 1'b1;

    // rotate left through a full turn
    step(LOAD, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      step(ROL, 8'h00, 1'b0, 1'b1, 1'b0, rol_q[i], 1'b0, rol_so[i]);

    // increment wrap
    step(LOAD, 8'hFE, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    step(INC,  8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(INC,  8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step(HOLD, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // decrement borrow, then ce low suppresses DEC and clears co
    step(DEC,  8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    step(DEC,  8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(DEC,  8'h00, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);

    // shift right with sin=1, then sclr while ce low
    step(LOAD, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(SHR,  8'h00, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0);
    step(SHR,  8'h00, 1'b1, 1'b1, 1'b0, 8'hC0, 1'b0, 1'b0);
    step(SHR,  8'h00, 1'b1, 1'b1, 1'b0, 8'hE0, 1'b0, 1'b0);
    step(HOLD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // shift left and rotate right
    step(LOAD, 8'h81, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0);
    step(SHL,  8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
    step(SHL,  8'h00, 1'b1, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
    step(ROR,  8'h00, 1'b0, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1);
    step(ROR,  8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0);

    // async clear mid-cycle while counting
    step(LOAD, 8'h36, 1'b0, 1'b1, 1'b0, 8'h36, 1'b0, 1'b0);
    step(INC,  8'h00, 1'b0, 1'b1, 1'b0, 8'h37, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    mode = INC; ce = 1'b1; sclr = 1'b0;
    #1 clrbar = 1'b0;
    #1;
    cmp("aclr_q", {56'd0, q}, 64'h00);
    cmp("aclr_co", {63'd0, co}, 64'd0);
    #1 clrbar = 1'b1;
    exp_q.push_back(8'h01);
    exp_co.push_back(1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
